// File: rtl/data_buffer_drain_pkg.sv
// data_buffer_drain_pkg: shared constants and types for the DataBuffer read-side drain
package data_buffer_drain_pkg;
  localparam int BUF_RD_LATENCY = 1;
  localparam int DRAIN_Q_DEPTH = 2;
  typedef logic [1:0] queue_cnt_t;
endpackage

// File: rtl/data_buffer_drain_if.sv
// data_buffer_drain_if: buffer read port plus downstream valid/ready stream
interface data_buffer_drain_if #(parameter int DATA_WIDTH = 64);
  logic                  r_empty;
  logic                  r_inc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  modport master (input r_empty, r_data, out_ready, output r_inc, out_valid, out_data);
  modport slave (output r_empty, r_data, out_ready, input r_inc, out_valid, out_data);
endinterface

// File: rtl/data_buffer_drain_skid_queue.sv
// data_buffer_drain_skid_queue: 2-entry shift queue with push/pop/clear and occupancy count
module data_buffer_drain_skid_queue
  import data_buffer_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output queue_cnt_t            count_o
);
  logic [DATA_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  queue_cnt_t            cnt_q, cnt_d;
  logic                  pop, wr_lo;
  // the write slot is chosen after the pop has shifted slot1 down
  always_comb begin
    pop   = pop_i & (cnt_q != '0);
    wr_lo = (cnt_q - queue_cnt_t'(pop)) == '0;
    s0_d  = push_i & wr_lo ? din_i : pop ? s1_q : s0_q;
    s1_d  = push_i & ~wr_lo ? din_i : s1_q;
    cnt_d = clear_i ? '0 : cnt_q + queue_cnt_t'(push_i) - queue_cnt_t'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q  <= '0;
      s1_q  <= '0;
      cnt_q <= '0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout_o  = s0_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/data_buffer_drain.sv
// data_buffer_drain: pops a DataBuffer through its registered read port and re-presents
// entries as a valid/ready stream via a 2-entry queue, with flush and a pop counter
module data_buffer_drain
  import data_buffer_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  data_buffer_drain_if.master    bus,
  input  logic                   flush_i,
  output logic [CNT_WIDTH-1:0]   pop_count_o
);
  logic [BUF_RD_LATENCY-1:0] in_flight_q, in_flight_d;
  logic                      squash_q, squash_d;
  logic [CNT_WIDTH-1:0]      pop_count_q, pop_count_d;
  queue_cnt_t                cnt, occ;
  logic                      capture, r_inc;
  // responses still in flight reserve a queue slot, so the queue can never overflow
  always_comb begin
    occ         = cnt + queue_cnt_t'($countones(in_flight_q));
    r_inc       = ~bus.r_empty & ~flush_i & (occ < queue_cnt_t'(DRAIN_Q_DEPTH));
    capture     = in_flight_q[BUF_RD_LATENCY-1] & ~squash_q;
    in_flight_d = BUF_RD_LATENCY'({in_flight_q, r_inc});
    squash_d    = flush_i & ((|in_flight_q) | r_inc);
    pop_count_d = pop_count_q + CNT_WIDTH'(r_inc);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q <= '0;
      squash_q    <= 1'b0;
      pop_count_q <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      squash_q    <= squash_d;
      pop_count_q <= pop_count_d;
    end
  end
  data_buffer_drain_skid_queue #(.DATA_WIDTH(DATA_WIDTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .pop_i   (bus.out_valid & bus.out_ready),
    .clear_i (flush_i),
    .din_i   (bus.r_data),
    .dout_o  (bus.out_data),
    .count_o (cnt)
  );
  assign bus.r_inc     = r_inc;
  assign bus.out_valid = cnt != '0;
  assign pop_count_o   = pop_count_q;
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(capture && cnt == queue_cnt_t'(DRAIN_Q_DEPTH)));
      assert (!(r_inc && bus.r_empty));
    end
  end
`endif
endmodule

// File: tb/tb_data_buffer_drain.sv
// tb_data_buffer_drain: directed vector table, corner sequences and a randomized run
// checked against a timestamped-queue reference model
module tb_data_buffer_drain;
  localparam int DW = 64;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [CW-1:0] pop_count;
  data_buffer_drain_if #(.DATA_WIDTH(DW)) bus ();
  data_buffer_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush_i(flush), .pop_count_o(pop_count)
  );
  always #5 clk = ~clk;
  logic          buf_valid = 1'b0;
  logic [DW-1:0] buf_data = '0;
  logic [DW-1:0] rdata = '0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  assign bus.r_empty = ~buf_valid;
  assign bus.r_data  = rdata;
  // 1-deep DataBuffer with a registered read port
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      rdata     <= '0;
    end else begin
      if (bus.r_inc) begin
        rdata     <= buf_data;
        buf_valid <= 1'b0;
      end
      if (wr_en) begin
        buf_valid <= 1'b1;
        buf_data  <= wr_data;
      end
    end
  end
  int errs = 0;
  int checks = 0;
  bit chk_en = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // reference model: every popped entry becomes visible two cycles after its pop
  typedef struct { logic [DW-1:0] d; int vis; } ent_t;
  ent_t mq[$];
  int cyc = 0;
  int pc_m = 0;
  always @(negedge clk) begin : mdl
    logic e_rinc, e_vld;
    if (chk_en && !rst) begin
      e_vld  = mq.size() > 0 && mq[0].vis <= cyc;
      e_rinc = buf_valid && !flush && mq.size() < 2;
      chk("model r_inc", DW'(bus.r_inc), DW'(e_rinc));
      chk("model out_valid", DW'(bus.out_valid), DW'(e_vld));
      if (e_vld) chk("model out_data", bus.out_data, mq[0].d);
      chk("model pop_count", DW'(pop_count), DW'(pc_m % (1 << CW)));
      if (e_vld && bus.out_ready) void'(mq.pop_front());
      if (flush) mq.delete();
      if (e_rinc) begin
        mq.push_back('{buf_data, cyc + 2});
        pc_m++;
      end
      cyc++;
    end
  end
  typedef struct {
    bit wr; logic [7:0] wd; bit rdy; bit fl;
    bit e_rinc; bit e_vld; logic [7:0] e_dat; int e_pc;
  } vec_t;
  vec_t tbl[28];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit seen;
    tbl[0]  = '{1, 8'hA5, 1, 0, 0, 0, 8'h00, 0};
    tbl[1]  = '{0, 8'h00, 1, 0, 1, 0, 8'h00, 0};
    tbl[2]  = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 1};
    tbl[3]  = '{0, 8'h00, 1, 0, 0, 1, 8'hA5, 1};
    tbl[4]  = '{1, 8'h11, 0, 0, 0, 0, 8'h00, 1};
    tbl[5]  = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 1};
    tbl[6]  = '{1, 8'h22, 0, 0, 0, 0, 8'h00, 2};
    tbl[7]  = '{0, 8'h00, 0, 0, 1, 1, 8'h11, 2};
    tbl[8]  = '{1, 8'h33, 0, 0, 0, 1, 8'h11, 3};
    tbl[9]  = '{0, 8'h00, 0, 0, 0, 1, 8'h11, 3};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 1, 8'h11, 3};
    tbl[11] = '{0, 8'h00, 1, 0, 0, 1, 8'h11, 3};
    tbl[12] = '{0, 8'h00, 1, 0, 1, 1, 8'h22, 3};
    tbl[13] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 4};
    tbl[14] = '{0, 8'h00, 1, 0, 0, 1, 8'h33, 4};
    tbl[15] = '{1, 8'h01, 0, 0, 0, 0, 8'h00, 4};
    tbl[16] = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 4};
    tbl[17] = '{1, 8'h02, 0, 0, 0, 0, 8'h00, 5};
    tbl[18] = '{0, 8'h00, 0, 0, 1, 1, 8'h01, 5};
    tbl[19] = '{0, 8'h00, 1, 0, 0, 1, 8'h01, 6};
    tbl[20] = '{0, 8'h00, 1, 0, 0, 1, 8'h02, 6};
    tbl[21] = '{1, 8'h55, 0, 0, 0, 0, 8'h00, 6};
    tbl[22] = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 6};
    tbl[23] = '{1, 8'h77, 0, 0, 0, 0, 8'h00, 7};
    tbl[24] = '{0, 8'h00, 0, 0, 1, 1, 8'h55, 7};
    tbl[25] = '{0, 8'h00, 0, 1, 0, 1, 8'h55, 8};
    tbl[26] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 8};
    tbl[27] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 8};
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset r_inc", DW'(bus.r_inc), '0);
    chk("reset out_valid", DW'(bus.out_valid), '0);
    chk("reset out_data", bus.out_data, '0);
    chk("reset pop_count", DW'(pop_count), '0);
    tick();
    rst = 1'b0;
    chk_en = 1;
    for (int i = 0; i < 28; i++) begin
      tick();
      wr_en = tbl[i].wr;
      wr_data = DW'(tbl[i].wd);
      bus.out_ready = tbl[i].rdy;
      flush = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d r_inc", i), DW'(bus.r_inc), DW'(tbl[i].e_rinc));
      chk($sformatf("vec%0d out_valid", i), DW'(bus.out_valid), DW'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("vec%0d out_data", i), bus.out_data, DW'(tbl[i].e_dat));
      chk($sformatf("vec%0d pop_count", i), DW'(pop_count), DW'(tbl[i].e_pc));
    end
    tick();
    wr_en = 1'b0;
    bus.out_ready = 1'b0;
    // async reset while the queue holds two entries
    wr_data = 64'hC1; wr_en = 1'b1; tick(); wr_en = 1'b0;
    repeat (3) tick();
    wr_data = 64'hC2; wr_en = 1'b1; tick(); wr_en = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("full before reset out_valid", DW'(bus.out_valid), DW'(1));
    chk("full before reset out_data", bus.out_data, 64'hC1);
    #2;
    chk_en = 0;
    rst = 1'b1;
    #1;
    chk("async reset out_valid", DW'(bus.out_valid), '0);
    chk("async reset pop_count", DW'(pop_count), '0);
    chk("async reset r_inc", DW'(bus.r_inc), '0);
    mq.delete();
    pc_m = 0;
    tick();
    rst = 1'b0;
    chk_en = 1;
    bus.out_ready = 1'b1;
    wr_data = 64'h99; wr_en = 1'b1; tick(); wr_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1;
        chk("post reset first data", bus.out_data, 64'h99);
      end
    end
    if (!seen) begin
      errs++;
      checks++;
      $display("FAIL post reset delivery: got no out_valid expected data 99");
    end
    // 16 more pops bring the total since reset to 17, which wraps a 4-bit counter to 1
    for (int i = 0; i < 16; i++) begin
      tick();
      wr_data = DW'(i + 16'h100);
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
    end
    repeat (3) tick();
    @(negedge clk);
    chk("counter wrap", DW'(pop_count), DW'(1));
    for (int i = 0; i < 400; i++) begin
      tick();
      wr_en = !buf_valid && ($urandom_range(0, 3) != 0);
      wr_data = {$urandom(), $urandom()};
      bus.out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
    end
    tick();
    wr_en = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("drained out_valid", DW'(bus.out_valid), '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
